// File: rtl/spsram_banked.sv
// Banked single-port SRAM: clears every row after reset, then serves reads with a fixed 2-cycle latency.
// Optional per-byte write enables (input i_bwe) are compiled in with `define SPSRAM_BANKED_BWE_EN.
module spsram_banked #(
    parameter int BW_DATA = 32,
    parameter int BW_ADDR = 5,
    parameter int N_BANK  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_wen,
    input  logic [BW_ADDR-1:0]   i_addr,
    input  logic [BW_DATA-1:0]   i_data,
`ifdef SPSRAM_BANKED_BWE_EN
    input  logic [BW_DATA/8-1:0] i_bwe,
`endif
    output logic                 o_rsp_valid,
    output logic [BW_DATA-1:0]   o_rsp_data,
    output logic                 o_init_done
);

    localparam int BW_BANK = $clog2(N_BANK);
    localparam int BW_ROW  = BW_ADDR - BW_BANK;
    localparam int N_ROW   = 1 << BW_ROW;
    localparam int N_BYTE  = BW_DATA / 8;
    localparam logic [BW_ROW-1:0] ROW_LAST = {BW_ROW{1'b1}};
    localparam logic [BW_ROW-1:0] ROW_ONE  = BW_ROW'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_r;
    logic [BW_ROW-1:0]   cnt_r;
    logic                req_ready_r;
    logic                init_done_r;

    logic [BW_DATA-1:0]  mem_r [N_BANK][N_ROW];
    logic [BW_DATA-1:0]  rd_word_r [N_BANK];
    logic [BW_BANK-1:0]  rd_bank_r;
    logic                s1_valid_r;
    logic                rsp_valid_r;
    logic [BW_DATA-1:0]  rsp_data_r;

    logic                acc_s;
    logic                rd_s;
    logic                init_wr_s;
    logic [BW_BANK-1:0]  bank_s;
    logic [BW_ROW-1:0]   row_s;
    logic [N_BANK-1:0]   bank_en_s;
    logic [N_BYTE-1:0]   byte_en_s;

    // Request decode; nothing is accepted while reset is applied
    always_comb begin
        acc_s     = i_req_valid & req_ready_r & ~i_rst;
        rd_s      = acc_s & ~i_req_wen;
        init_wr_s = (state_r == ST_INIT);
        bank_s    = i_addr[BW_ADDR-1 -: BW_BANK];
        row_s     = i_addr[BW_ROW-1:0];
        bank_en_s = '0;
        for (int b = 0; b < N_BANK; b++) begin
            bank_en_s[b] = acc_s & (bank_s == BW_BANK'(b));
        end
`ifdef SPSRAM_BANKED_BWE_EN
        byte_en_s = i_bwe;
`else
        byte_en_s = {N_BYTE{1'b1}};
`endif
    end

    // Bank arrays: INIT clear of one row in every bank, else the selected bank's write or read
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < N_BANK; b++) begin
            if (init_wr_s) begin
                mem_r[b][cnt_r] <= '0;
            end else if (bank_en_s[b] && i_req_wen) begin
                for (int k = 0; k < N_BYTE; k++) begin
                    if (byte_en_s[k]) begin
                        mem_r[b][row_s][8*k +: 8] <= i_data[8*k +: 8];
                    end
                end
            end else if (bank_en_s[b]) begin
                rd_word_r[b] <= mem_r[b][row_s];
            end
        end
    end

    // Control FSM: sweep the clear counter across all rows, then serve requests until reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= ST_INIT;
            cnt_r       <= '0;
            req_ready_r <= 1'b0;
            init_done_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    cnt_r <= cnt_r + ROW_ONE;
                    if (cnt_r == ROW_LAST) begin
                        state_r     <= ST_RUN;
                        req_ready_r <= 1'b1;
                        init_done_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    req_ready_r <= 1'b1;
                    init_done_r <= 1'b1;
                end
                default: begin
                    state_r     <= ST_INIT;
                    cnt_r       <= '0;
                    req_ready_r <= 1'b0;
                    init_done_r <= 1'b0;
                end
            endcase
        end
    end

    // Read pipeline: stage 1 holds the bank index, stage 2 registers the bank-muxed word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid_r  <= 1'b0;
            rd_bank_r   <= '0;
            rsp_valid_r <= 1'b0;
            rsp_data_r  <= '0;
        end else begin
            s1_valid_r  <= rd_s;
            rsp_valid_r <= s1_valid_r;
            if (rd_s) begin
                rd_bank_r <= bank_s;
            end
            if (s1_valid_r) begin
                rsp_data_r <= rd_word_r[rd_bank_r];
            end
        end
    end

    assign o_req_ready = req_ready_r;
    assign o_init_done = init_done_r;
    assign o_rsp_valid = rsp_valid_r;
    assign o_rsp_data  = rsp_data_r;

endmodule

// File: doc/spsram_banked.md
SPSRAM_BANKED -- requirements
Module: spsram_banked

Interface
REQ-001 SHALL have parameter BW_DATA, default 32: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter BW_ADDR, default 5: total word-address width.
REQ-003 SHALL have parameter N_BANK, default 2: bank count; power of two, 2..16.
REQ-004 SHALL derive localparam BW_BANK = log2(N_BANK) and BW_ROW = BW_ADDR - BW_BANK.
REQ-005 SHALL have port i_clk, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port i_req_valid, input, 1: request present.
REQ-008 SHALL have port o_req_ready, output, 1: request accepted when both this and i_req_valid are high.
REQ-009 SHALL have port i_req_wen, input, 1: 1 = write, 0 = read.
REQ-010 SHALL have port i_addr, input, BW_ADDR: bank = i_addr[BW_ADDR-1 -: BW_BANK], row = i_addr[BW_ROW-1:0].
REQ-011 SHALL have port i_data, input, BW_DATA: write data.
REQ-012 SHALL have port o_rsp_valid, output, 1: read data valid, one-cycle pulse per accepted read.
REQ-013 SHALL have port o_rsp_data, output, BW_DATA: read data.
REQ-014 SHALL have port o_init_done, output, 1: high once post-reset clearing has completed.

Function
REQ-015 SHALL hold N_BANK arrays of 2^BW_ROW words each; exactly one bank is enabled per accepted request.
REQ-016 SHALL run a two-state FSM: INIT -> RUN when the clear counter reaches 2^BW_ROW-1; RUN persists until reset.
REQ-017 In INIT, SHALL write zero to row cnt in all banks every cycle, cnt counting 0 .. 2^BW_ROW-1, with o_req_ready=0 and o_init_done=0.
REQ-018 In RUN, SHALL hold o_req_ready=1 and o_init_done=1; there is no backpressure on responses.
REQ-019 An accepted write SHALL update the selected bank/row at that clock edge and produce no response.
REQ-020 An accepted read SHALL assert o_rsp_valid exactly 2 cycles after acceptance: stage 1 registers the array read and bank index, stage 2 registers the bank-muxed data.
REQ-021 SHALL accept back-to-back reads every cycle and return responses in order at full throughput.
REQ-022 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-023 When o_rsp_valid=0, o_rsp_data SHALL hold its last value.
REQ-024 Requests presented while o_req_ready=0 SHALL be ignored, without side effects.

Reset
REQ-025 With i_rst high at a clock edge, SHALL enter INIT with cnt=0, o_rsp_valid=0, o_rsp_data=0, o_init_done=0, o_req_ready=0, and both pipeline stages invalidated.
REQ-026 Reset asserted mid-operation, including mid-INIT, SHALL discard in-flight reads (no response) and restart clearing from row 0.

Configuration
REQ-027 With macro SPSRAM_BANKED_BWE_EN defined, SHALL add input i_bwe [BW_DATA/8-1:0]; a write updates only bytes whose bit is 1, and i_bwe=0 makes the write a no-op.
REQ-028 Without SPSRAM_BANKED_BWE_EN, i_bwe SHALL be absent and every write SHALL update the full word.
REQ-029 The INIT clear SHALL write full words in both configurations.

Verification
REQ-030 Defaults, reset then idle: o_req_ready low for 16 cycles after reset release, o_init_done high on cycle 16; reads of address 0 and 31 return 0.
REQ-031 Write 0xA5A5_0001 to address 3 and 0x5A5A_0002 to address 19, then read both back-to-back: o_rsp_valid at +2 and +3 cycles with those values in order; confirms bank separation.
REQ-032 Write 0x1234_5678 to address 7, read address 7 on the next cycle: o_rsp_data=0x1234_5678 two cycles later.
REQ-033 Issue a read, assert i_rst one cycle later: no o_rsp_valid pulse; re-clear completes and address 7 reads 0.
REQ-034 SPSRAM_BANKED_BWE_EN defined: write 0xFFFF_FFFF, then write 0x0000_0000 with i_bwe=4'b0101, then read: 0xFF00_FF00.
REQ-035 N_BANK=4, BW_ADDR=6: write all 64 addresses with data equal to the address, read them sequentially: 64 consecutive valid responses matching.
